dino_jump_ctrl: RTL

- Dinosaur vertical-motion controller, directly upstream of the dinosaur sprite renderer that produces px_dinosaur.
- Turns the player's jump button into a per-frame dinosaur screen row, using a rise/fall state machine with integer gravity.
- Updates once per video frame on frame_tick, which the VGA timing block derives from vs.
- Also supplies the running-leg animation phase and a landing pulse for scoring and sound.

---
 rtl/dino_pkg.sv | 6 +
 rtl/dino_jump_ctrl_if.sv | 17 +
 rtl/btn_sync_edge.sv | 22 ++
 rtl/dino_jump_ctrl.sv | 119 +++++++++++
 4 files changed

// File: rtl/dino_pkg.sv
// dino_pkg: shared dinosaur-game geometry defaults and motion state encoding
package dino_pkg;
    localparam int Y_W_DEF      = 10;
    localparam int GROUND_Y_DEF = 400;
    typedef enum logic [1:0] {RUN, RISE, FALL, HALT} dino_state_e;
endpackage

// File: rtl/dino_jump_ctrl_if.sv
// dino_jump_ctrl_if: frame/button controls in, sprite position and status out
interface dino_jump_ctrl_if import dino_pkg::*; #(
    parameter int Y_W = Y_W_DEF
);
    logic           frame_tick;
    logic           jump_btn;
    logic           enable;
    logic           freeze;
    logic [Y_W-1:0] dino_y;
    logic           airborne;
    logic           landed;
    logic           leg_phase;
    modport master (output frame_tick, jump_btn, enable, freeze,
                    input  dino_y, airborne, landed, leg_phase);
    modport slave  (input  frame_tick, jump_btn, enable, freeze,
                    output dino_y, airborne, landed, leg_phase);
endinterface

// File: rtl/btn_sync_edge.sv
// btn_sync_edge: 2-FF synchronizer for an async level plus one-cycle rising-edge pulse
module btn_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic pulse
);
    logic meta_q, sync_q, prev_q;
    // shift the raw level through two sync stages and keep the previous synced value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end
    assign pulse = sync_q & ~prev_q;
endmodule

// File: rtl/dino_jump_ctrl.sv
// dino_jump_ctrl: per-frame rise/fall jump physics, leg animation and landing pulse
module dino_jump_ctrl import dino_pkg::*; #(
    parameter int Y_W      = Y_W_DEF,
    parameter int GROUND_Y = GROUND_Y_DEF,
    parameter int JUMP_V   = 12,
    parameter int GRAVITY  = 1,
    parameter int MAX_H    = 200,
    parameter int LEG_DIV  = 6
) (
    input logic              CLK,
    input logic              RESET,
    dino_jump_ctrl_if.slave  bus
);
    localparam logic [1:0] S_RUN  = RUN;
    localparam logic [1:0] S_RISE = RISE;
    localparam logic [1:0] S_FALL = FALL;
    localparam logic [1:0] S_HALT = HALT;
    localparam int LC_W = $clog2(LEG_DIV + 1);
    localparam logic [Y_W-1:0]  JV     = Y_W'(JUMP_V);
    localparam logic [Y_W-1:0]  GV     = Y_W'(GRAVITY);
    localparam logic [Y_W-1:0]  MH     = Y_W'(MAX_H);
    localparam logic [Y_W-1:0]  GY     = Y_W'(GROUND_Y);
    localparam logic [LC_W-1:0] LC_MAX = LC_W'(LEG_DIV - 1);

    logic [1:0]      state_q, state_d;
    logic [Y_W-1:0]  height_q, height_d, vel_q, vel_d, dino_y_q, dino_y_d;
    logic [LC_W-1:0] leg_cnt_q, leg_cnt_d;
    logic            pending_q, pending_d, leg_phase_q, leg_phase_d;
    logic            landed_q, landed_d, airborne_q, airborne_d;
    logic            jedge, rise_done, leg_wrap;
    logic [Y_W:0]    rise_sum, fall_nv;
    logic signed [Y_W:0] rise_nv;

    btn_sync_edge u_jump_sync (.clk(CLK), .rst(RESET), .din(bus.jump_btn), .pulse(jedge));

    // one extra bit keeps the height sum and fall step from wrapping; signed for velocity decay
    assign rise_sum  = {1'b0, height_q} + {1'b0, vel_q};
    assign rise_nv   = $signed({1'b0, vel_q}) - $signed({1'b0, GV});
    assign rise_done = rise_nv[Y_W] | (rise_nv == '0);
    assign fall_nv   = {1'b0, vel_q} + {1'b0, GV};
    assign leg_wrap  = leg_cnt_q == LC_MAX;

    // next-state physics: enable beats freeze beats frame_tick work
    always_comb begin
        state_d     = state_q;
        height_d    = height_q;
        vel_d       = vel_q;
        leg_cnt_d   = leg_cnt_q;
        leg_phase_d = leg_phase_q;
        landed_d    = 1'b0;
        pending_d   = (jedge | pending_q) & (state_q == S_RUN) & ~bus.frame_tick;
        if (!bus.enable) begin
            state_d     = S_RUN;
            height_d    = '0;
            vel_d       = '0;
            pending_d   = 1'b0;
            leg_cnt_d   = '0;
            leg_phase_d = 1'b0;
        end else if (bus.freeze) begin
            state_d   = S_HALT;
            pending_d = 1'b0;
        end else if (bus.frame_tick) begin
            if (state_q == S_RUN && (pending_q | jedge)) begin
                height_d = (JV > MH) ? MH : JV;
                vel_d    = JV - GV;
                state_d  = (JV == GV) ? S_FALL : S_RISE;
            end else if (state_q == S_RUN) begin
                leg_cnt_d   = leg_wrap ? '0 : leg_cnt_q + LC_W'(1);
                leg_phase_d = leg_phase_q ^ leg_wrap;
            end else if (state_q == S_RISE) begin
                height_d = (rise_sum > {1'b0, MH}) ? MH : rise_sum[Y_W-1:0];
                vel_d    = rise_done ? '0 : rise_nv[Y_W-1:0];
                state_d  = rise_done ? S_FALL : S_RISE;
            end else if (state_q == S_FALL) begin
                if ({1'b0, height_q} <= fall_nv) begin
                    height_d = '0;
                    vel_d    = '0;
                    landed_d = 1'b1;
                    state_d  = S_RUN;
                end else begin
                    height_d = height_q - fall_nv[Y_W-1:0];
                    vel_d    = fall_nv[Y_W-1:0];
                end
            end
        end
        dino_y_d   = GY - height_d;
        airborne_d = (state_d == S_RISE) | (state_d == S_FALL);
    end

    // register motion state and the renderer-facing outputs
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= S_RUN;
            height_q    <= '0;
            vel_q       <= '0;
            pending_q   <= 1'b0;
            leg_cnt_q   <= '0;
            leg_phase_q <= 1'b0;
            landed_q    <= 1'b0;
            dino_y_q    <= GY;
            airborne_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            height_q    <= height_d;
            vel_q       <= vel_d;
            pending_q   <= pending_d;
            leg_cnt_q   <= leg_cnt_d;
            leg_phase_q <= leg_phase_d;
            landed_q    <= landed_d;
            dino_y_q    <= dino_y_d;
            airborne_q  <= airborne_d;
        end
    end

    assign bus.dino_y    = dino_y_q;
    assign bus.airborne  = airborne_q;
    assign bus.landed    = landed_q;
    assign bus.leg_phase = leg_phase_q;
endmodule
